// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg: shared constants and width helpers for the fifo_level slice.
//   clog2 / level_width : pointer and fill-level width derivation
//   DEF_*               : default parameter values used by the interface and modules
package fifo_level_pkg;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // The level counter needs one extra bit to represent a completely full FIFO.
    function automatic int level_width(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

    localparam int DEF_DATA_WIDTH    = 32'sd16;
    localparam int DEF_DATA_DEPTH    = 32'sd32;
    localparam int DEF_AFULL_THRESH  = 32'sd28;
    localparam int DEF_AEMPTY_THRESH = 32'sd4;
    localparam int DEF_LEVEL_WIDTH   = level_width(DEF_DATA_DEPTH);

endpackage

// File: rtl/fifo_level_if.sv
// fifo_level_if: producer/consumer handshake bundle for fifo_level.
//   master : drives write, read, data_in, err_clr; observes data and status
//   slave  : the FIFO side
interface fifo_level_if
    import fifo_level_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH
) ();

    localparam int LW = level_width(DATA_DEPTH);

    logic                  write;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty_flag;
    logic                  full_flag;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, read, data_in, err_clr,
        input  data_out, empty_flag, full_flag, almost_empty, almost_full,
               level, overflow, underflow
    );

    modport slave (
        input  write, read, data_in, err_clr,
        output data_out, empty_flag, full_flag, almost_empty, almost_full,
               level, overflow, underflow
    );

endinterface

// File: rtl/fifo_level_mem.sv
// fifo_level_mem: simple dual-port RAM for fifo_level; storage itself is never reset.
//   clk          : clock
//   rst          : clears the registered read-data latch (standard mode only)
//   we/waddr/wdata : synchronous write port
//   re/raddr     : read enable (standard mode only) and read address
//   rdata        : read data; registered, or asynchronous when FIFO_LEVEL_FWFT_EN is defined
// Configuration macro: FIFO_LEVEL_FWFT_EN selects the asynchronous read port.
module fifo_level_mem
    import fifo_level_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DATA_DEPTH = DEF_DATA_DEPTH,
    localparam int AW         = clog2(DATA_DEPTH)
) (
    input  logic                  clk,
`ifndef FIFO_LEVEL_FWFT_EN
    input  logic                  rst,
    input  logic                  re,
`endif
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

`ifdef FIFO_LEVEL_FWFT_EN
    // Head word is presented combinationally for fall-through operation.
    assign rdata = mem_r[raddr];
`else
    logic [DATA_WIDTH-1:0] rdata_r;

    // Registered read: the latch holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
`endif

endmodule

// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with fill level, almost-full/empty flags and
// sticky overflow/underflow errors.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, dominates all requests
//   bus : fifo_level_if.slave (write/read/data_in/err_clr in; data/status out)
// Configuration macro: FIFO_LEVEL_FWFT_EN enables first-word fall-through
// reads; otherwise data_out is registered with one cycle of read latency.
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH    = DEF_DATA_DEPTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic        clk,
    input  logic        rst,
    fifo_level_if.slave bus
);

    localparam int            AW        = clog2(DATA_DEPTH);
    localparam int            LW        = level_width(DATA_DEPTH);
    localparam logic [LW-1:0] DEPTH_LV  = LW'(DATA_DEPTH);
    localparam logic [LW-1:0] AFULL_LV  = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AEMPTY_LV = LW'(AEMPTY_THRESH);
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          empty_r;
    logic          full_r;
    logic          aempty_r;
    logic          afull_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          rd_ok_s;
    logic          wr_ok_s;
    logic [LW-1:0] level_next_s;

    // Request acceptance and next fill level. A write at full is only taken
    // when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok_s      = bus.read & ~empty_r;
        wr_ok_s      = bus.write & (~full_r | rd_ok_s);
        level_next_s = level_r;
        if (wr_ok_s && !rd_ok_s) begin
            level_next_s = level_r + LEVEL_ONE;
        end else if (rd_ok_s && !wr_ok_s) begin
            level_next_s = level_r - LEVEL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointers, level, flags (derived from the next level) and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LEVEL_ZERO;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            aempty_r    <= 1'b1;
            afull_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r  <= level_next_s;
            empty_r  <= (level_next_s == LEVEL_ZERO);
            full_r   <= (level_next_s == DEPTH_LV);
            aempty_r <= (level_next_s <= AEMPTY_LV);
            afull_r  <= (level_next_s >= AFULL_LV);
            // A new error event outranks a simultaneous clear.
            if (bus.write && !wr_ok_s) begin
                overflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_r <= 1'b0;
            end
            if (bus.read && !rd_ok_s) begin
                underflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_r <= 1'b0;
            end
        end
    end

    fifo_level_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_mem (
        .clk   (clk),
`ifndef FIFO_LEVEL_FWFT_EN
        .rst   (rst),
        .re    (rd_ok_s),
`endif
        .we    (wr_ok_s),
        .waddr (wr_ptr_r),
        .wdata (bus.data_in),
        .raddr (rd_ptr_r),
        .rdata (bus.data_out)
    );

    assign bus.empty_flag   = empty_r;
    assign bus.full_flag    = full_r;
    assign bus.almost_empty = aempty_r;
    assign bus.almost_full  = afull_r;
    assign bus.level        = level_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: scoreboard bench for fifo_level. Stimulus updates a queue-based
// reference model and pushes the expected post-edge state; a monitor pops and
// compares one entry after every rising edge.
module tb_fifo_level;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    typedef struct {
        int              level;
        bit              empty;
        bit              full;
        bit              aempty;
        bit              afull;
        bit              ovf;
        bit              unf;
        bit              dout_chk;
        logic [DW-1:0]   dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t          exp_q[$];
    int            model_q[$];
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_dout;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;

    always #5 clk = ~clk;

    fifo_level_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bus ();

    fifo_level #(
        .DATA_WIDTH    (DW),
        .DATA_DEPTH    (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
        end
    endtask

    // Apply one cycle of inputs and record what the FIFO must look like after the edge.
    task automatic step(input bit rs, input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
        exp_t e;
        bit   rd_ok;
        bit   wr_ok;
        @(negedge clk);
        rst         = rs;
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        bus.err_clr = clr;
        if (rs) begin
            model_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else begin
            rd_ok = r && (model_q.size() > 0);
            wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = DW'(model_q.pop_front());
            if (wr_ok) model_q.push_back(int'(d));
            if (w && !wr_ok) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (r && !rd_ok) m_unf = 1'b1;
            else if (clr) m_unf = 1'b0;
        end
        e.level  = model_q.size();
        e.empty  = (e.level == 0);
        e.full   = (e.level == DEPTH);
        e.aempty = (e.level <= AE);
        e.afull  = (e.level >= AF);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
`ifdef FIFO_LEVEL_FWFT_EN
        e.dout_chk = (e.level > 0);
        e.dout     = e.dout_chk ? DW'(model_q[0]) : '0;
`else
        e.dout_chk = 1'b1;
        e.dout     = m_dout;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT state against the oldest expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("level",        32'(bus.level),        32'(e.level));
                check("empty_flag",   32'(bus.empty_flag),   32'(e.empty));
                check("full_flag",    32'(bus.full_flag),    32'(e.full));
                check("almost_empty", 32'(bus.almost_empty), 32'(e.aempty));
                check("almost_full",  32'(bus.almost_full),  32'(e.afull));
                check("overflow",     32'(bus.overflow),     32'(e.ovf));
                check("underflow",    32'(bus.underflow),    32'(e.unf));
                if (e.dout_chk) check("data_out", 32'(bus.data_out), 32'(e.dout));
            end
        end
    end

    initial begin
        int wprob;
        int rprob;
        rst         = 1'b1;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = '0;
        bus.err_clr = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        m_dout      = '0;

        // Reset, fill past full, drain past empty, clear errors.
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 1; i <= 33; i++) step(1'b0, 1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Full with simultaneous read/write, then drain.
        for (int i = 1; i <= 32; i++) step(1'b0, 1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 100; i <= 109; i++) step(1'b0, 1'b1, 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);

        // Empty with simultaneous read/write, then a set event racing err_clr.
        step(1'b0, 1'b1, 1'b1, 16'h0007, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h0200 + i), 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0055, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Single word into empty, held without read, then popped.
        step(1'b0, 1'b1, 1'b0, 16'hABCD, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Randomized phases alternating fill-biased and drain-biased traffic.
        for (int i = 0; i < 2000; i++) begin
            case ((i / 100) % 4)
                0:       begin wprob = 80; rprob = 30; end
                1:       begin wprob = 50; rprob = 50; end
                2:       begin wprob = 25; rprob = 80; end
                default: begin wprob = 90; rprob = 90; end
            endcase
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < wprob,
                 $urandom_range(0, 99) < rprob,
                 DW'($urandom),
                 $urandom_range(0, 24) == 0);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Let the monitor consume the remaining expectations, within a bound.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
Parametrised synchronous single-clock FIFO that extends the basic write/read FIFO.
- Adds a fill-level output, parameterised almost-full/almost-empty flags, sticky overflow/underflow error flags and a defined simultaneous read/write rule at full and empty.
- Sits between producer and consumer blocks in the same clock domain.
- Instantiated wherever the plain FIFO was used and back-pressure is needed before hard full.

Parameters:
DATA_WIDTH, 16, word width in bits (>=1)
DATA_DEPTH, 32, number of entries; power of two, >=4
AFULL_THRESH, 28, almost_full asserted when level >= AFULL_THRESH (1..DATA_DEPTH-1)
AEMPTY_THRESH, 4, almost_empty asserted when level <= AEMPTY_THRESH (1..DATA_DEPTH-1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
write  in  1  write request
read  in  1  read request
data_in  in  DATA_WIDTH  write data
err_clr  in  1  clears sticky overflow/underflow
data_out  out  DATA_WIDTH  read data
empty_flag  out  1  FIFO holds 0 words
full_flag  out  1  FIFO holds DATA_DEPTH words
almost_empty  out  1  level <= AEMPTY_THRESH
almost_full  out  1  level >= AFULL_THRESH
level  out  $clog2(DATA_DEPTH)+1  current word count, 0..DATA_DEPTH
overflow  out  1  sticky: write refused because full
underflow  out  1  sticky: read refused because empty

Behaviour:
- Reset (rst=1 at edge): pointers=0, level=0, empty_flag=1, full_flag=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0. Memory contents not cleared. Reset dominates all requests in the same cycle. Mid-operation reset discards all stored data.
- Pointers: AW=$clog2(DATA_DEPTH) bits each; wrap naturally from DATA_DEPTH-1 to 0.
- rd_ok = read & !empty_flag.
- wr_ok = write & (!full_flag | rd_ok): a write at full is accepted only with a simultaneous accepted read.
- Write at empty with read: write accepted, read refused, underflow set.
- level' = level + wr_ok - rd_ok. All flags are registered and derived from level', so they are valid the cycle after the edge.
- Standard mode read latency is 1 cycle: on rd_ok, data_out <= mem[rd_ptr] at that edge. Otherwise data_out holds its value.
- Write-to-readable latency: a word written at edge N can be read by a request sampled at edge N+1.
- overflow <= 1 when write & !wr_ok. underflow <= 1 when read & !rd_ok.
- Both sticky until err_clr=1 or rst. A set event in the same cycle as err_clr wins: the flag stays 1.
- No state machine beyond pointer/level counters. Arithmetic is unsigned; level never exceeds DATA_DEPTH or goes below 0.

Optional Feature:
Macro FIFO_LEVEL_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever empty_flag=0.
  - read acts as pop/acknowledge; the next word appears the cycle after rd_ok.
  - A word written into an empty FIFO is visible on data_out one cycle after the write edge.
  - data_out is undefined while empty_flag=1.
- Undefined: standard registered read described above.
- Flags, level and error behaviour are identical in both modes.

Decomposition:
- Package fifo_level_pkg: function clog2 / AW derivation, level width constant, default threshold constants.
- Sub-module fifo_level_mem: simple dual-port RAM.
  - One write port (we, waddr, wdata).
  - One read port, registered or asynchronous depending on FIFO_LEVEL_FWFT_EN.
  - No reset on storage.

Test Plan (DATA_WIDTH=16, DATA_DEPTH=32, default thresholds):
- Reset for 2 cycles -> empty_flag=1, full_flag=0, level=0, almost_empty=1, data_out=0, overflow=underflow=0.
- Write 1..32 on consecutive cycles:
  - level steps 1..32.
  - almost_empty drops after the 5th write.
  - almost_full rises after the 28th write.
  - full_flag=1 after the 32nd write.
  - A 33rd write (value 33) -> overflow=1, level stays 32.
- Read 32 times:
  - Standard mode: data_out 1..32 in order, one cycle after each read.
  - empty_flag=1 after the last read.
  - An extra read -> underflow=1, data_out holds 32.
  - Then err_clr=1 -> both error flags 0.
- Fill to 32, then write=read=1 for 10 cycles with values 100..109:
  - level stays 32, full_flag stays 1, no overflow.
  - Outputs are 1..10.
- From empty, write=read=1 with value 7:
  - Write accepted, underflow=1, level=1.
  - Next read returns 7.
- Write 5 words, assert rst mid-stream with write=1 -> level=0, empty_flag=1. The word presented during reset is not stored.
- With FIFO_LEVEL_FWFT_EN:
  - Write 0xABCD into empty -> data_out=0xABCD one cycle later with read=0.
  - A read pops it and empty_flag=1 next cycle.
